demux_tdm_1_4: RTL and testbench
================================

# demux_tdm_1_4

Time-division 1-to-4 demultiplexer: the receiving end of a 4-slot TDM link driven by a `sel` counter that cycles a 4:1 multiplexer. It marks slot 0 with a `frame` strobe, captures one word per clock into four slot registers, and publishes all four at once with a one-cycle `valid` pulse. It sits between the serial link and downstream logic that needs the four channels in parallel, and flags aborted or corrupted frames on `err`.

## Interface
- `WIDTH`, default 1: bits per slot, i.e. the width of `in` and of each output.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  WIDTH  TDM data, one slot word per cycle.
- `frame`  input  1  high in the cycle carrying slot 0.
- `out0`..`out3`  output  WIDTH each  last complete frame, slots 0..3 (registered).
- `valid`  output  1  one-cycle pulse: `out0`..`out3` were just updated.
- `err`  output  1  one-cycle pulse: frame aborted or, with parity enabled, failed parity.

## Operation
- Reset (`reset`=1 at an edge):
  - state IDLE, slot counter 0, slot registers 0;
  - `out0`..`out3`=0, `valid`=0, `err`=0.
  - Reset wins over every other event, including mid-frame; the partial frame is discarded with no `err`.
- States:
  - IDLE: `in` ignored while `frame`=0. `frame`=1 captures `in` into slot 0, sets counter 1, goes to RECV.
  - RECV, `frame`=0: captures `in` into slot[counter], counter+1.
  - After the last slot (slot 3, or slot 4 with parity) the block commits and returns to IDLE.
- Commit without parity: registered `out0`..`out3` load slots 0..3 together; `valid` pulses.
- Abort: `frame`=1 while in RECV, including the last-slot cycle.
  - Partial frame discarded; `out*` unchanged.
  - `err` pulses.
  - That cycle's `in` becomes slot 0 of a new frame; counter 1; stays in RECV.
- Back-to-back frames: `frame` in the first cycle after the last slot is accepted from IDLE with no gap and no error.
- `valid` and `err` never assert in the same cycle.
- The counter never wraps silently. It stops at the last slot and returns to IDLE.

## Timing
- `frame`+slot 0 in cycle t; slots 1..3 in t+1..t+3.
- `out*` and `valid` are visible in cycle t+4, so latency is 4 cycles from `frame`. With parity this becomes t+5.
- An abort at cycle a gives `err`=1 in cycle a+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- There is no backpressure. `valid` is a pulse, and `out*` hold their value until the next commit.

## Configuration
- `DEMUX_PARITY_EN` defined:
  - The frame has 5 slots. Slot 4 bit 0 is even parity: its bit 0 equals the XOR of all 4×WIDTH data bits. Other bits of slot 4 are ignored.
  - Match: commit in t+5, `valid` pulses.
  - Mismatch: `out*` unchanged, `valid` stays 0, `err` pulses in t+5.
  - An abort during slot 4 follows the normal abort rule.
- Not defined:
  - The frame has 4 slots, as described above.
  - `err` reports aborts only, and no parity logic is generated.

## Test plan
- Reset, then idle stimulus (`frame`=0, `in` toggling for 10 cycles): all outputs stay 0, `valid` stays 0.
- WIDTH=1, `frame` at t with `in`=1,0,1,1: at t+4 `out0..3`=1,0,1,1 and `valid`=1 for exactly one cycle. The outputs hold until the next commit.
- Two back-to-back frames, 1,1,0,0 then 0,1,0,1 (second `frame` at t+4): `valid` at t+4 and t+8, `out*`=0,1,0,1 after t+8, no `err`.
- Abort: `frame` at t, then `frame` again at t+2. `err`=1 at t+3, previous `out*` unchanged, and the new frame commits at t+6.
- `reset` asserted at t+2 mid-frame: all outputs 0 at t+3, and there is no `valid`/`err` until a fresh frame.
- `DEMUX_PARITY_EN`, data 1,0,1,1:
  - parity bit 1: `valid` at t+5;
  - parity bit 0: `err` at t+5 and `out*` unchanged.

Source files
------------

// File: rtl/demux_tdm_1_4.sv
// demux_tdm_1_4: receiving end of a 4-slot TDM link.
// A frame strobe marks slot 0. The following slots are captured into slot
// registers, and the four registered outputs are then published together
// with a one-cycle valid pulse. An aborted frame produces a one-cycle err pulse.
// Optional feature: define DEMUX_PARITY_EN to add a fifth slot that carries
// even parity over all data bits; a parity mismatch reports err instead of valid.
module demux_tdm_1_4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             frame,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             valid,
  output logic             err
);

`ifdef DEMUX_PARITY_EN
  localparam int unsigned NSLOT = 5;
`else
  localparam int unsigned NSLOT = 4;
`endif
  localparam int unsigned LAST  = NSLOT - 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {IDLE, RECV} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0][WIDTH-1:0]   slot_q, slot_d;
  logic [3:0][WIDTH-1:0]   out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  assign out0  = out_q[0];
  assign out1  = out_q[1];
  assign out2  = out_q[2];
  assign out3  = out_q[3];
  assign valid = valid_q;
  assign err   = err_q;

  // Next-state, slot capture and commit decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame) begin
          slot_d[0] = in;
          cnt_d     = CNT_W'(1);
          state_d   = RECV;
        end
      end
      RECV: begin
        if (frame) begin
          // Abort: drop the partial frame and restart with this word as slot 0
          err_d     = 1'b1;
          slot_d[0] = in;
          cnt_d     = CNT_W'(1);
        end else if (cnt_q == CNT_W'(LAST)) begin
          state_d = IDLE;
          cnt_d   = CNT_W'(0);
`ifdef DEMUX_PARITY_EN
          // Parity slot: bit 0 must equal the XOR of all data bits
          if (in[0] == (^slot_q)) begin
            out_d   = slot_q;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
`else
          // Last data slot is forwarded straight into the output register
          out_d    = slot_q;
          out_d[3] = in;
          valid_d  = 1'b1;
`endif
        end else begin
          slot_d[cnt_q[1:0]] = in;
          cnt_d              = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_demux_tdm_1_4.sv
// Testbench for demux_tdm_1_4 (WIDTH=1). The stimulus pushes the expected
// valid/err events, with their cycle and output values, into a queue. A monitor
// on the falling edge pops an event each time valid or err is seen and compares it.
module tb_demux_tdm_1_4;
  localparam int unsigned W = 1;
`ifdef DEMUX_PARITY_EN
  localparam int LAT   = 5;
  localparam int LASTS = 4;
  localparam bit PAR   = 1'b1;
`else
  localparam int LAT   = 4;
  localparam int LASTS = 3;
  localparam bit PAR   = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         frame;
  logic [W-1:0] in;
  logic [W-1:0] out0, out1, out2, out3;
  logic         valid, err;
  logic [3:0]   obs;

  demux_tdm_1_4 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in(in), .frame(frame),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {out0[0], out1[0], out2[0], out3[0]};

  typedef struct {
    int         at;
    bit         is_err;
    logic [3:0] outs;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [3:0] cur_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT reports an event
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_err_exclusive", 32'(valid & err), 32'd0);
      if (valid === 1'b1 || err === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got valid=%0b err=%0b, expected none (cycle %0d)",
                   valid, err, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("event_cycle", 32'(cyc), 32'(e.at));
          chk("event_kind_err", 32'(err), 32'(e.is_err));
          chk("event_outs", 32'(obs), 32'(e.outs));
        end
      end
    end
  end

  task automatic step(input bit f, input bit d, input bit r = 1'b0);
    frame = f;
    in    = W'(d);
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'(i));
  endtask

  // d[3] is slot 0 ... d[0] is slot 3. abort_prev: this frame strobe cuts a frame short.
  task automatic send_frame(input logic [3:0] d, input bit abort_prev, input bit par_ok);
    int   t0;
    exp_t e;
    t0 = cyc;
    if (abort_prev) begin
      e.at = t0 + 1; e.is_err = 1'b1; e.outs = cur_out;
      sbq.push_back(e);
    end
    if (PAR && !par_ok) begin
      e.at = t0 + LAT; e.is_err = 1'b1; e.outs = cur_out;
    end else begin
      e.at = t0 + LAT; e.is_err = 1'b0; e.outs = d;
      cur_out = d;
    end
    sbq.push_back(e);
    for (int i = 0; i < 4; i++) step(i == 0, d[3-i]);
    if (PAR) step(1'b0, par_ok ? (^d) : ~(^d));
  endtask

  // Send slot 0 with the frame strobe plus n-1 further words, leaving the frame unfinished
  task automatic send_partial(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) step(i == 0, (i < 4) ? d[3-i] : 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    frame = 1'b0;
    in    = '0;
    cur_out = 4'b0000;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    mon_en = 1'b1;
    chk("reset_outs", 32'(obs), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Idle link with toggling data: nothing may happen
    idle(10);
    chk("idle_outs", 32'(obs), 32'd0);

    // Single frame 1,0,1,1, then the outputs hold
    send_frame(4'b1011, 1'b0, 1'b1);
    idle(LAT + 2);
    chk("hold_outs", 32'(obs), 32'b1011);
    chk("hold_valid", 32'(valid), 32'd0);

    // Back-to-back frames with no gap
    send_frame(4'b1100, 1'b0, 1'b1);
    send_frame(4'b0101, 1'b0, 1'b1);
    idle(LAT + 1);
    chk("b2b_outs", 32'(obs), 32'b0101);

    // Abort after two slots; the new frame commits normally
    send_partial(4'b1000, 2);
    send_frame(4'b0010, 1'b1, 1'b1);
    idle(LAT + 1);
    chk("abort_outs", 32'(obs), 32'b0010);

    // Abort in the final slot cycle
    send_partial(4'b1110, LASTS);
    send_frame(4'b1001, 1'b1, 1'b1);
    idle(LAT + 1);
    chk("abort_last_outs", 32'(obs), 32'b1001);

    // Reset mid-frame: outputs cleared, trailing words ignored
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    cur_out = 4'b0000;
    chk("midreset_outs", 32'(obs), 32'd0);
    chk("midreset_valid", 32'(valid), 32'd0);
    chk("midreset_err", 32'(err), 32'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(LAT + 2);
    chk("post_reset_outs", 32'(obs), 32'd0);

    // Fresh frame after reset
    send_frame(4'b0110, 1'b0, 1'b1);
    idle(LAT + 1);
    chk("fresh_outs", 32'(obs), 32'b0110);

`ifdef DEMUX_PARITY_EN
    // Parity: good parity commits, bad parity gives err with outputs held
    send_frame(4'b1011, 1'b0, 1'b1);
    idle(LAT + 1);
    chk("par_ok_outs", 32'(obs), 32'b1011);
    send_frame(4'b0110, 1'b0, 1'b0);
    idle(LAT + 1);
    chk("par_bad_outs", 32'(obs), 32'b1011);
`endif

    idle(LAT + 2);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
